// File: rtl/game_pkg.sv
// Shared game definitions for the collision/heart logic.
// Holds the collision FSM state type, the heart capacity and the heart-count width.
// The heart counter uses the same definitions.
package game_pkg;

  localparam int unsigned MAX_HEARTS = 3;
  localparam int unsigned HEART_W    = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_COOLDOWN,
    S_DEAD
  } game_state_e;

endpackage

// File: rtl/collision_event_gen.sv
// Turns per-pixel overlaps into once-per-frame game events.
//
// Overlaps seen during a frame are latched into sticky flags. On each startOfFrame the
// flags, together with that cycle's overlap, decide the frame's outcome:
//   - hit while armed: collision pulse and a cooldown of COOLDOWN_FRAMES frames;
//   - heart pickup with room for another heart: bonus pulse.
// During cooldown the car is invulnerable and blinks every BLINK_FRAMES frames.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   game_running               round in play; low returns the block to idle
//   startOfFrame               one-cycle pulse at frame start
//   drawing_request_car        player-car pixel active
//   drawing_request_obstacle   obstacle pixel active
//   drawing_request_heart      bonus-heart pixel active
//   heartsNum                  current heart count
//   collision, bonus           one-cycle event pulses (cycle after startOfFrame)
//   invulnerable               high during cooldown
//   blink_hide                 high when the car should be hidden
//   game_over                  high once hearts are exhausted
// All outputs come straight from flops.
module collision_event_gen
  import game_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_running,
  input  logic               startOfFrame,
  input  logic               drawing_request_car,
  input  logic               drawing_request_obstacle,
  input  logic               drawing_request_heart,
  input  logic [HEART_W-1:0] heartsNum,
  output logic               collision,
  output logic               bonus,
  output logic               invulnerable,
  output logic               blink_hide,
  output logic               game_over
);

  localparam logic [7:0]         CooldownLoad = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0]         BlinkLast    = 8'(BLINK_FRAMES - 1);
  localparam logic [HEART_W-1:0] FullHearts   = HEART_W'(MAX_HEARTS);

  game_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        hit_flag_q, hit_flag_d;
  logic        bonus_flag_q, bonus_flag_d;
  logic        collision_q, collision_d;
  logic        bonus_q, bonus_d;
  logic        invulnerable_q, invulnerable_d;
  logic        blink_hide_q, blink_hide_d;
  logic        game_over_q, game_over_d;

  logic hit_now, bonus_now, hit_frame, bonus_frame, bonus_ok;

  assign hit_now     = drawing_request_car & drawing_request_obstacle;
  assign bonus_now   = drawing_request_car & drawing_request_heart;
  // The decision cycle's own overlap counts as part of the ending frame.
  assign hit_frame   = hit_flag_q | hit_now;
  assign bonus_frame = bonus_flag_q | bonus_now;
  assign bonus_ok    = heartsNum < FullHearts;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hit_flag_d   = hit_frame;
    bonus_flag_d = bonus_frame;
    collision_d  = 1'b0;
    bonus_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        hit_flag_d   = 1'b0;
        bonus_flag_d = 1'b0;
        cnt_d        = '0;
        if (game_running) begin
          state_d = S_ARMED;
        end
      end

      S_ARMED, S_COOLDOWN: begin
        if (!game_running) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          hit_flag_d   = 1'b0;
          bonus_flag_d = 1'b0;
        end else if (heartsNum == '0) begin
          state_d      = S_DEAD;
          cnt_d        = '0;
          hit_flag_d   = 1'b0;
          bonus_flag_d = 1'b0;
        end else if (startOfFrame) begin
          hit_flag_d   = 1'b0;
          bonus_flag_d = 1'b0;
          if (state_q == S_ARMED) begin
            if (hit_frame) begin
              // A hit swallows any bonus from the same frame.
              collision_d = 1'b1;
              cnt_d       = CooldownLoad;
              state_d     = S_COOLDOWN;
            end else begin
              bonus_d = bonus_frame & bonus_ok;
            end
          end else begin
            // Hits are ignored while invulnerable, including on the exit frame.
            bonus_d = bonus_frame & bonus_ok;
            cnt_d   = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
              state_d = S_ARMED;
            end
          end
        end
      end

      S_DEAD: begin
        hit_flag_d   = 1'b0;
        bonus_flag_d = 1'b0;
        cnt_d        = '0;
        if (!game_running) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Blink divider: restarts on every cooldown entry so the car is shown first.
  always_comb begin
    blink_cnt_d  = blink_cnt_q;
    blink_hide_d = blink_hide_q;
    if (state_d != S_COOLDOWN) begin
      blink_cnt_d  = '0;
      blink_hide_d = 1'b0;
    end else if (state_q == S_COOLDOWN && startOfFrame) begin
      if (blink_cnt_q >= BlinkLast) begin
        blink_cnt_d  = '0;
        blink_hide_d = ~blink_hide_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  assign invulnerable_d = (state_d == S_COOLDOWN);
  assign game_over_d    = (state_d == S_DEAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      blink_cnt_q    <= '0;
      hit_flag_q     <= 1'b0;
      bonus_flag_q   <= 1'b0;
      collision_q    <= 1'b0;
      bonus_q        <= 1'b0;
      invulnerable_q <= 1'b0;
      blink_hide_q   <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      hit_flag_q     <= hit_flag_d;
      bonus_flag_q   <= bonus_flag_d;
      collision_q    <= collision_d;
      bonus_q        <= bonus_d;
      invulnerable_q <= invulnerable_d;
      blink_hide_q   <= blink_hide_d;
      game_over_q    <= game_over_d;
    end
  end

  assign collision    = collision_q;
  assign bonus        = bonus_q;
  assign invulnerable = invulnerable_q;
  assign blink_hide   = blink_hide_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_collision_event_gen.sv
module tb_collision_event_gen;

  localparam int CD = 4;
  localparam int BL = 2;
  localparam int FL = 10;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_COOL  = 2;
  localparam int M_DEAD  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       game_running = 1'b0;
  logic       sof = 1'b0;
  logic       car = 1'b0;
  logic       obs = 1'b0;
  logic       heart = 1'b0;
  logic [1:0] hearts = 2'd3;
  logic       collision, bonus, invulnerable, blink_hide, game_over;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  collision_event_gen #(
    .COOLDOWN_FRAMES(CD),
    .BLINK_FRAMES   (BL)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .game_running            (game_running),
    .startOfFrame            (sof),
    .drawing_request_car     (car),
    .drawing_request_obstacle(obs),
    .drawing_request_heart   (heart),
    .heartsNum               (hearts),
    .collision               (collision),
    .bonus                   (bonus),
    .invulnerable            (invulnerable),
    .blink_hide              (blink_hide),
    .game_over               (game_over)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the rules.
  int  m_st = M_IDLE;
  bit  m_hit, m_bon;
  int  m_left, m_cf;
  bit  model_on = 0;
  bit  e_coll, e_bon;
  int  frame_no = 0;
  int  coll_cnt = 0;
  int  bonus_cnt = 0;
  int  coll_while_inv = 0;
  int  coll_frames[$];
  bit  prev_inv = 0;

  initial begin
    bit hit_f, bon_f;
    forever begin
      @(posedge clk);
      e_coll = 0;
      e_bon  = 0;
      if (reset) begin
        m_st = M_IDLE; m_hit = 0; m_bon = 0; m_left = 0; m_cf = 0; model_on = 1;
      end else begin
        if (sof) frame_no++;
        if (m_st == M_IDLE) begin
          m_hit = 0; m_bon = 0;
          if (game_running) m_st = M_ARMED;
        end else if (!game_running) begin
          m_st = M_IDLE; m_hit = 0; m_bon = 0; m_left = 0;
        end else if (m_st == M_DEAD) begin
          m_hit = 0; m_bon = 0;
        end else if (hearts == 2'd0) begin
          m_st = M_DEAD; m_hit = 0; m_bon = 0;
        end else begin
          hit_f = m_hit || (car && obs);
          bon_f = m_bon || (car && heart);
          if (sof) begin
            m_hit = 0; m_bon = 0;
            if (m_st == M_ARMED && hit_f) begin
              e_coll = 1; m_st = M_COOL; m_left = CD; m_cf = 0;
            end else begin
              if (bon_f && hearts < 2'd3) e_bon = 1;
              if (m_st == M_COOL) begin
                m_left--;
                m_cf++;
                if (m_left == 0) m_st = M_ARMED;
              end
            end
          end else begin
            m_hit = hit_f; m_bon = bon_f;
          end
        end
      end
      #1;
      if (model_on) begin
        chk("collision", collision, 32'(e_coll));
        chk("bonus", bonus, 32'(e_bon));
        chk("invulnerable", invulnerable, 32'(m_st == M_COOL));
        chk("blink_hide", blink_hide, 32'(m_st == M_COOL && ((m_cf / BL) % 2) == 1));
        chk("game_over", game_over, 32'(m_st == M_DEAD));
      end
      if (collision === 1'b1) begin
        coll_cnt++;
        coll_frames.push_back(frame_no);
        if (prev_inv) coll_while_inv++;
      end
      if (bonus === 1'b1) bonus_cnt++;
      prev_inv = (invulnerable === 1'b1);
    end
  end

  task automatic cycle_in(input bit s, input bit c, input bit o, input bit h);
    sof = s; car = c; obs = o; heart = h;
    @(negedge clk);
  endtask

  // One frame: startOfFrame first, overlaps on cycles 2.. of the frame.
  task automatic frame(input int n_obs, input int n_heart);
    int n;
    n = (n_obs > n_heart) ? n_obs : n_heart;
    cycle_in(1, 0, 0, 0);
    for (int i = 1; i < FL; i++) begin
      cycle_in(0, (i >= 2 && i < 2 + n), (i >= 2 && i < 2 + n_obs), (i >= 2 && i < 2 + n_heart));
    end
  endtask

  task automatic restart(input logic [1:0] h);
    reset = 1;
    cycle_in(0, 0, 0, 0);
    reset = 0;
    game_running = 1;
    hearts = h;
    cycle_in(0, 0, 0, 0);
  endtask

  initial begin
    int c0, b0, f0, inv0;
    int pat[6];
    pat[0] = 0; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0; pat[5] = 0;

    @(negedge clk);
    @(negedge clk);
    chk("reset_collision", collision, 0);
    chk("reset_game_over", game_over, 0);
    chk("reset_invulnerable", invulnerable, 0);
    reset = 0;

    // Single hit: pulse right after the deciding startOfFrame.
    restart(3);
    c0 = coll_cnt;
    frame(5, 0);
    chk("hit_no_early_pulse", 32'(coll_cnt - c0), 0);
    cycle_in(1, 0, 0, 0);
    chk("hit_pulse_after_sof", collision, 1);
    chk("hit_invulnerable", invulnerable, 1);
    cycle_in(0, 0, 0, 0);
    chk("hit_pulse_one_cycle", collision, 0);
    chk("hit_still_invulnerable", invulnerable, 1);
    chk("hit_one_pulse", 32'(coll_cnt - c0), 1);

    // Overlap every frame: pulses 5 frames apart, none while invulnerable.
    restart(3);
    f0 = coll_frames.size();
    inv0 = coll_while_inv;
    for (int k = 0; k < 13; k++) frame(3, 0);
    chk("cool_pulse_count", 32'(coll_frames.size() - f0), 3);
    for (int k = f0 + 1; k < coll_frames.size(); k++)
      chk("cool_spacing", 32'(coll_frames[k] - coll_frames[k-1]), 5);
    chk("cool_none_while_inv", 32'(coll_while_inv - inv0), 0);

    // Hit and heart in the same frame: hit wins.
    restart(2);
    frame(4, 4);
    cycle_in(1, 0, 0, 0);
    chk("both_collision", collision, 1);
    chk("both_bonus", bonus, 0);

    // Bonus only with room for another heart.
    restart(3);
    b0 = bonus_cnt;
    frame(0, 3);
    frame(0, 0);
    chk("full_hearts_no_bonus", 32'(bonus_cnt - b0), 0);
    hearts = 1;
    b0 = bonus_cnt;
    frame(0, 3);
    frame(0, 0);
    chk("bonus_one_pulse", 32'(bonus_cnt - b0), 1);

    // Hearts exhausted.
    restart(3);
    hearts = 0;
    cycle_in(0, 0, 0, 0);
    chk("dead_game_over", game_over, 1);
    hearts = 2;
    c0 = coll_cnt;
    b0 = bonus_cnt;
    frame(3, 3);
    frame(3, 3);
    frame(0, 0);
    chk("dead_no_collision", 32'(coll_cnt - c0), 0);
    chk("dead_no_bonus", 32'(bonus_cnt - b0), 0);
    chk("dead_holds", game_over, 1);
    game_running = 0;
    cycle_in(0, 0, 0, 0);
    chk("dead_to_idle", game_over, 0);

    // Reset mid-cooldown clears outputs at once.
    restart(3);
    frame(3, 0);
    frame(0, 0);
    frame(0, 0);
    chk("pre_reset_invulnerable", invulnerable, 1);
    #2 reset = 1;
    #1;
    chk("async_collision", collision, 0);
    chk("async_bonus", bonus, 0);
    chk("async_invulnerable", invulnerable, 0);
    chk("async_blink_hide", blink_hide, 0);
    chk("async_game_over", game_over, 0);
    @(negedge clk);
    reset = 0;
    cycle_in(0, 0, 0, 0);
    c0 = coll_cnt;
    frame(0, 0);
    frame(0, 0);
    chk("no_residual_pulse", 32'(coll_cnt - c0), 0);
    chk("no_residual_inv", invulnerable, 0);

    // Blink pattern across a fresh cooldown.
    frame(3, 0);
    for (int k = 0; k < 6; k++) begin
      frame(0, 0);
      chk("blink_pattern", blink_hide, 32'(pat[k]));
    end

    // Randomized play checked by the model every cycle.
    restart(3);
    for (int f = 0; f < 300; f++) begin
      int len, r;
      r = $urandom_range(0, 19);
      hearts = (r == 0) ? 2'd0 : 2'(1 + r % 3);
      game_running = ($urandom_range(0, 24) != 0);
      len = $urandom_range(3, 10);
      for (int i = 0; i < len; i++) begin
        reset = ($urandom_range(0, 399) == 0);
        cycle_in(i == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0);
      end
      reset = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/collision_event_gen.md
COLLISION_EVENT_GEN -- requirements
Module: collision_event_gen

Interface
REQ-001 SHALL have parameter COOLDOWN_FRAMES, default 60: invulnerability length in frames after a hit (range 1..255).
REQ-002 SHALL have parameter BLINK_FRAMES, default 8: frames per blink half-period during invulnerability (range 1..COOLDOWN_FRAMES).
REQ-003 SHALL have ports:
  - clk  input  1  system clock.
  - reset  input  1  asynchronous, active-high.
  - game_running  input  1  high while a round is in play.
  - startOfFrame  input  1  one-cycle pulse at frame start.
  - drawing_request_car  input  1  player-car pixel active.
  - drawing_request_obstacle  input  1  obstacle pixel active.
  - drawing_request_heart  input  1  bonus-heart pixel active.
  - heartsNum  input  2  current heart count from the heart counter.
  - collision  output  1  one-cycle hit pulse to the heart counter.
  - bonus  output  1  one-cycle heart-pickup pulse.
  - invulnerable  output  1  high during cooldown.
  - blink_hide  output  1  high when the car is to be hidden.
  - game_over  output  1  high once hearts are exhausted.

Function
REQ-004 SHALL implement FSM states S_IDLE, S_ARMED, S_COOLDOWN, S_DEAD.
REQ-005 In S_IDLE, SHALL move to S_ARMED on the first clock with game_running=1, and SHALL clear both overlap flags.
REQ-006 SHALL set hit_flag when drawing_request_car & drawing_request_obstacle in any cycle; the flag is sticky until the next startOfFrame.
REQ-007 SHALL set bonus_flag when drawing_request_car & drawing_request_heart in any cycle; the flag is sticky until the next startOfFrame.
REQ-008 The frame decision SHALL use (flag OR current-cycle overlap) on the startOfFrame cycle; both flags SHALL then clear on that edge.
REQ-009 In S_ARMED, with a hit at the frame decision and heartsNum>0:
  - collision SHALL be 1 for exactly the cycle after the startOfFrame edge;
  - the cooldown counter SHALL load COOLDOWN_FRAMES;
  - the next state SHALL be S_COOLDOWN.
REQ-010 In S_COOLDOWN, SHALL ignore hit_flag, never assert collision, and decrement the counter on each startOfFrame.
REQ-011 In S_COOLDOWN, when the counter reaches 0 on a startOfFrame, SHALL return to S_ARMED; that frame's hits are discarded.
REQ-012 In S_ARMED or S_COOLDOWN, a bonus at the frame decision with heartsNum<3 SHALL pulse bonus for one cycle with the same timing as collision.
REQ-013 A bonus at the frame decision with heartsNum=3 SHALL produce no pulse.
REQ-014 When hit and bonus occur in the same frame in S_ARMED, collision SHALL pulse and bonus SHALL be suppressed.
REQ-015 When heartsNum=0 is sampled in S_ARMED or S_COOLDOWN, SHALL enter S_DEAD; game_over=1 in S_DEAD; no pulses in S_DEAD.
REQ-016 When game_running=0 in any non-idle state, SHALL return to S_IDLE on the next clock and clear the counter and flags.
REQ-017 invulnerable SHALL equal (state==S_COOLDOWN).
REQ-018 blink_hide SHALL be 0 outside S_COOLDOWN; inside it SHALL toggle every BLINK_FRAMES frames, starting at 0 on entry.
REQ-019 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.
REQ-020 The cooldown counter SHALL be 8 bits, SHALL saturate at 0, and SHALL never wrap.

Reset
REQ-021 On reset=1, regardless of clock, SHALL set state=S_IDLE, counter=0, both flags=0, and all outputs=0.
REQ-022 Reset asserted mid-cooldown SHALL abort the cooldown with no residual pulse after release.

Structure
REQ-023 The state enum, MAX_HEARTS=3 and the heart width (2 bits) SHALL live in shared package game_pkg, also used by the heart counter.
REQ-024 SHALL be a single module with no sub-module; the blink divider is an internal counter.

Verification
REQ-025 Hit, no cooldown yet: run, heartsNum=3, car&obstacle overlap 5 pixels in frame 1 -> exactly one collision pulse, one cycle after the next startOfFrame; invulnerable=1 next cycle.
REQ-026 Hit during cooldown: COOLDOWN_FRAMES=4, overlap in every frame -> collision pulses spaced exactly 5 frames apart; none during invulnerable=1.
REQ-027 Simultaneous hit and bonus: car overlaps obstacle and heart in one frame, heartsNum=2 -> collision=1, bonus=0.
REQ-028 Full hearts and bonus: heartsNum=3, heart overlap -> no bonus pulse. Repeat with heartsNum=1 -> one bonus pulse.
REQ-029 Hearts exhausted: drive heartsNum=0 -> game_over=1 next cycle; further overlaps give no pulses. Deassert game_running -> S_IDLE, game_over=0.
REQ-030 Reset mid-cooldown: assert reset mid-cooldown with BLINK_FRAMES=2 -> all outputs 0 immediately. Check blink_hide pattern 0,0,1,1,0,0 per frame in a fresh cooldown.
